// File: rtl/branch_pred_ctrl_if.sv
// branch_pred_ctrl_if: IF predict and EX resolve signals between the pipeline and the branch predictor
interface branch_pred_ctrl_if;
  logic [31:0] if_pc;
  logic        if_is_br;
  logic [31:0] if_imm;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [2:0]  ex_br_type;
  logic        ex_br;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;
  modport master (
    output if_pc, if_is_br, if_imm, ex_valid, ex_br_type, ex_br, ex_pc, ex_target, ex_pred_taken, stall,
    input  pred_taken, pred_target, flush, redirect_pc, br_cnt, mispred_cnt
  );
  modport slave (
    input  if_pc, if_is_br, if_imm, ex_valid, ex_br_type, ex_br, ex_pc, ex_target, ex_pred_taken, stall,
    output pred_taken, pred_target, flush, redirect_pc, br_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: 2-bit saturating counter branch predictor with EX-stage resolve, flush and redirect.
// BR_STATS_EN adds saturating resolved-branch and misprediction counters.
module branch_pred_ctrl #(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input logic clk,
  input logic rstn,
  branch_pred_ctrl_if.slave bp
);
  localparam int N = 1 << IDX_W;
  logic [N-1:0][1:0] tbl_q;
  logic [IDX_W-1:0]  if_idx, ex_idx;
  logic [1:0]        cur, cnt_d;
  logic              res, mispred, train;
  assign if_idx = bp.if_pc[IDX_W+1:2];
  assign ex_idx = bp.ex_pc[IDX_W+1:2];
  assign cur    = tbl_q[ex_idx];
  always_comb begin
    res            = bp.ex_valid && (bp.ex_br_type != 3'd0) && (bp.ex_br_type != 3'd7);
    mispred        = res && (bp.ex_br != bp.ex_pred_taken);
    train          = res && !bp.stall;
    cnt_d          = bp.ex_br ? ((cur == 2'b11) ? cur : cur + 2'd1) : ((cur == 2'b00) ? cur : cur - 2'd1);
    bp.pred_taken  = rstn && bp.if_is_br && tbl_q[if_idx][1];
    bp.pred_target = bp.if_pc + bp.if_imm;
    bp.flush       = rstn && mispred && !bp.stall;
    bp.redirect_pc = bp.flush ? (bp.ex_br ? bp.ex_target : bp.ex_pc + 32'd4) : 32'd0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tbl_q <= {N{CNT_INIT}};
    else if (train) tbl_q[ex_idx] <= cnt_d;
  end
`ifdef BR_STATS_EN
  logic [31:0] br_cnt_q, mispred_cnt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else if (train) begin
      br_cnt_q      <= (&br_cnt_q) ? br_cnt_q : br_cnt_q + 32'd1;
      mispred_cnt_q <= (mispred && !(&mispred_cnt_q)) ? mispred_cnt_q + 32'd1 : mispred_cnt_q;
    end
  end
  assign bp.br_cnt      = br_cnt_q;
  assign bp.mispred_cnt = mispred_cnt_q;
`else
  assign bp.br_cnt      = 32'd0;
  assign bp.mispred_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: directed and randomized checks of branch_pred_ctrl against a counter-table model
module tb_branch_pred_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int mc[16];
  logic [31:0] e_br = 0, e_mis = 0;
  branch_pred_ctrl_if bp();
  branch_pred_ctrl dut (.clk(clk), .rstn(rstn), .bp(bp));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) mc[i] = 1;
    e_br = 0;
    e_mis = 0;
  endtask
  task automatic set_ex(input logic v, input logic [2:0] t, input logic br, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pt, input logic st);
    bp.ex_valid = v; bp.ex_br_type = t; bp.ex_br = br; bp.ex_pc = pc;
    bp.ex_target = tgt; bp.ex_pred_taken = pt; bp.stall = st;
  endtask
  task automatic cyc();
    bit res, mis, fl;
    int k;
    #1;
    res = bp.ex_valid && bp.ex_br_type >= 3'd1 && bp.ex_br_type <= 3'd6;
    mis = res && (bp.ex_br != bp.ex_pred_taken);
    fl  = mis && !bp.stall;
    chk("pred_taken", {31'd0, bp.pred_taken}, {31'd0, bp.if_is_br && mc[bp.if_pc[5:2]] >= 2});
    chk("pred_target", bp.pred_target, bp.if_pc + bp.if_imm);
    chk("flush", {31'd0, bp.flush}, {31'd0, fl});
    chk("redirect_pc", bp.redirect_pc, fl ? (bp.ex_br ? bp.ex_target : bp.ex_pc + 32'd4) : 32'd0);
    chk("br_cnt", bp.br_cnt, e_br);
    chk("mispred_cnt", bp.mispred_cnt, e_mis);
    @(posedge clk);
    if (res && !bp.stall) begin
      k = bp.ex_pc[5:2];
      mc[k] = bp.ex_br ? ((mc[k] + 1 > 3) ? 3 : mc[k] + 1) : ((mc[k] - 1 < 0) ? 0 : mc[k] - 1);
`ifdef BR_STATS_EN
      e_br = e_br + 1;
      if (mis) e_mis = e_mis + 1;
`endif
    end
    #1;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_flush"}, {31'd0, bp.flush}, 32'd0);
    chk({tag, "_redirect"}, bp.redirect_pc, 32'd0);
    chk({tag, "_pred"}, {31'd0, bp.pred_taken}, 32'd0);
    chk({tag, "_br_cnt"}, bp.br_cnt, 32'd0);
    chk({tag, "_mis_cnt"}, bp.mispred_cnt, 32'd0);
  endtask
  initial begin
    model_reset();
    bp.if_pc = 32'h40; bp.if_is_br = 1'b1; bp.if_imm = 32'h10;
    set_ex(1'b1, 3'd1, 1'b1, 32'h40, 32'h50, 1'b0, 1'b0);
    #2;
    chk_reset_outputs("rst");
    @(posedge clk); @(posedge clk);
    #1 rstn = 1'b1;
    set_ex(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("tp_pred0", {31'd0, bp.pred_taken}, 32'd0);
    chk("tp_target0", bp.pred_target, 32'h50);
    cyc();
    set_ex(1'b1, 3'd1, 1'b1, 32'h40, 32'h50, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1 chk("tp_redirect50", bp.redirect_pc, 32'h50);
      cyc();
    end
    set_ex(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 chk("tp_pred_trained", {31'd0, bp.pred_taken}, 32'd1);
    cyc();
    bp.if_pc = 32'h7C;
    set_ex(1'b1, 3'd2, 1'b1, 32'h7C, 32'h100, 1'b1, 1'b0);
    cyc(); cyc();
    set_ex(1'b1, 3'd2, 1'b0, 32'h7C, 32'h100, 1'b1, 1'b0);
    #1 chk("tp_redirect80", bp.redirect_pc, 32'h80);
    cyc();
    set_ex(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 chk("tp_weak_taken", {31'd0, bp.pred_taken}, 32'd1);
    cyc();
    bp.if_pc = 32'h40;
    set_ex(1'b1, 3'd1, 1'b0, 32'h40, 32'h50, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc();
    bp.stall = 1'b0;
    cyc(); cyc();
    set_ex(1'b1, 3'd0, 1'b1, 32'h40, 32'h50, 1'b0, 1'b0);
    cyc();
    set_ex(1'b1, 3'd7, 1'b1, 32'h40, 32'h50, 1'b0, 1'b0);
    cyc();
    set_ex(1'b1, 3'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
    #1 chk("tp_wrap_flush", {31'd0, bp.flush}, 32'd1);
    chk("tp_wrap_redirect", bp.redirect_pc, 32'h0);
    cyc();
    for (int n = 0; n < 2000; n++) begin
      bp.if_pc    = {$urandom_range(0, 3), 24'h0, 2'b0, 4'($urandom), 2'b0};
      if ($urandom_range(0, 9) == 0) bp.if_pc = $urandom;
      bp.if_is_br = 1'($urandom);
      bp.if_imm   = $urandom;
      set_ex($urandom_range(0, 7) != 0, 3'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 32'($urandom) & 32'hFFFF_FFFC : bp.if_pc,
             $urandom, 1'($urandom), $urandom_range(0, 4) == 0);
      cyc();
      if (n == 1000) begin
        rstn = 1'b0;
        #1 chk_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
